one_wire_tx: RTL and testbench
==============================

# one_wire_tx

One-wire transmit engine that drains the 32-entry one-wire byte buffer onto the bus. On `start` it issues a 1-Wire reset/presence sequence, then fetches `byte_count` bytes from buffer addresses 0..byte_count-1 using the buffer's `read_en`/`data_dv` handshake. Each byte is serialised LSB-first as standard 1-Wire write slots through an open-drain pull-low output. It is the consumer end of the buffer that the control path fills.

## Interface
- `CLKS_PER_US`, 50, clock cycles per microsecond; all slot timing derives from it.
- `FETCH_TIMEOUT`, 15, maximum cycles to wait for `data_dv` after raising `read_en`.
- `clk` in 1 system clock.
- `reset` in 1 asynchronous, active-low reset.
- `start` in 1 begin a transaction; sampled only in IDLE.
- `byte_count` in 6 number of bytes to send; 0..32; values >32 are clamped to 32.
- `read_address` out 5 buffer address of the byte being fetched.
- `read_en` out 1 buffer read request.
- `data_in` in 8 buffer read data; valid when `data_dv`=1.
- `data_dv` in 1 buffer read-data valid.
- `ow_in` in 1 raw bus level; asynchronous.
- `ow_drive_low` out 1 1 = pull the bus low; 0 = release.
- `busy` out 1 transaction in progress.
- `done` out 1 one-cycle pulse at transaction end.
- `presence` out 1 presence detected; valid from `done` until next `start`.
- `error` out 1 fetch timeout or no presence; valid with `done`.

## Operation
- Reset values: all outputs 0 and `read_address`=0. The state is IDLE. The microsecond and bit counters are cleared.
- `ow_in` passes through a 2-flop synchroniser before any use.
- A free-running microsecond tick counter runs in every state except IDLE. It is cleared on each state entry.
- IDLE: on `start`=1, latch the clamped `byte_count`, clear `presence`/`error`, set `busy`, and go to RST_LOW.
- RST_LOW: drive low for 480 µs, then go to RST_WAIT.
- RST_WAIT: release the bus. At 70 µs after release, sample the synchronised `ow_in`; `presence` = (sample==0). Go to RST_RECOVER.
- RST_RECOVER: release the bus for 410 µs. If `byte_count`=0, go to DONE. Otherwise set address to 0 and go to FETCH.
- FETCH: hold `read_en`=1 with `read_address` stable until `data_dv`=1.
  - In that cycle, capture `data_in`, drop `read_en`, clear the bit index, and go to BIT_LOW.
  - If `FETCH_TIMEOUT` cycles pass with no `data_dv`, set `error`, drop `read_en`, and go to DONE.
- BIT_LOW: drive low for 6 µs if the current bit is 1, or 60 µs if it is 0. Then go to BIT_REC.
- BIT_REC: release the bus for 64 µs (bit 1) or 10 µs (bit 0). Every slot is 70 µs total.
  - Then advance the bit index. After bit 7, increment the address.
  - If the address equals the latched count, go to DONE; otherwise go to FETCH.
- DONE: pulse `done` for one cycle, clear `busy`, and return to IDLE.
- `start` is ignored while `busy`=1.
- A `data_dv` pulse outside FETCH is ignored.
- If `reset` is asserted mid-operation, the block immediately releases the bus, drops `read_en`, and returns to IDLE with no `done` pulse.

## Timing
- `busy` rises 1 cycle after `start` is sampled, and `ow_drive_low` rises in the same cycle.
- Reset sequence: exactly 960·CLKS_PER_US cycles from first low to the FETCH or DONE entry.
- Fetch latency: `read_en` is high from FETCH entry through the cycle `data_dv` is seen; the first slot's low phase starts the next cycle.
- Bit durations are exact multiples of CLKS_PER_US, with a tolerance of 0 cycles.
- `done` follows the last BIT_REC cycle by 1 cycle. `presence` and `error` are stable when `done`=1.

## Configuration
- `ONE_WIRE_TX_PRESENCE_EN` defined:
  - If the presence sample reads 1, set `error` and go to DONE after RST_RECOVER, sending no bytes.
- Undefined:
  - `presence` is tied to 0.
  - The sample is not taken, and the transfer always proceeds after the reset sequence.
  - `error` reports fetch timeout only.

## Test plan
- CLKS_PER_US=2, `byte_count`=1, buffer[0]=0xA5, device answers presence -> 960 low cycles, then presence, 8 slots of 140 cycles with low phases 12,120,12,120,120,12,120,12 cycles; `done`=1, `presence`=1, `error`=0.
- `byte_count`=3, buffer returns `data_dv` 2 cycles after `read_en` -> `read_address` is 0,1,2 across three fetches and 24 slots total.
- No device present (`ow_in` held 1), macro defined -> `error`=1, `presence`=0, zero write slots, `read_en` never asserted. With the macro undefined, the bytes are sent.
- `data_dv` never asserted -> `read_en` stays high for 15 cycles, then `error`=1, `done` pulses, and the bus is released.
- `byte_count`=40 -> exactly 32 bytes sent, with addresses 0..31.
- `reset` pulled low during a bit-0 low phase -> `ow_drive_low`=0 and `read_en`=0 asynchronously. After release the state is IDLE, `busy`=0, and there is no `done`.

Source files
------------

// File: rtl/one_wire_tx_if.sv
// one_wire_tx_if: buffer-read, one-wire bus and status signals of the one-wire transmit engine.
interface one_wire_tx_if;
  logic       start;
  logic [5:0] byte_count;
  logic [4:0] read_address;
  logic       read_en;
  logic [7:0] data_in;
  logic       data_dv;
  logic       ow_in;
  logic       ow_drive_low;
  logic       busy;
  logic       done;
  logic       presence;
  logic       error;
  modport master (
    output start, byte_count, data_in, data_dv, ow_in,
    input  read_address, read_en, ow_drive_low, busy, done, presence, error
  );
  modport slave (
    input  start, byte_count, data_in, data_dv, ow_in,
    output read_address, read_en, ow_drive_low, busy, done, presence, error
  );
endinterface

// File: rtl/one_wire_tx.sv
// one_wire_tx: drains the one-wire byte buffer as reset/presence plus LSB-first write slots.
// Define ONE_WIRE_TX_PRESENCE_EN to sample presence and abort the transfer when no device answers.
module one_wire_tx #(
  parameter int CLKS_PER_US   = 50,
  parameter int FETCH_TIMEOUT = 15
) (
  input logic          clk_i,
  input logic          reset_ni,
  one_wire_tx_if.slave bus
);
  localparam int CW = $clog2(CLKS_PER_US + 1);
  localparam int FW = $clog2(FETCH_TIMEOUT + 1);
  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_RST_LOW  = 3'd1;
  localparam logic [2:0] S_RST_WAIT = 3'd2;
  localparam logic [2:0] S_RST_REC  = 3'd3;
  localparam logic [2:0] S_FETCH    = 3'd4;
  localparam logic [2:0] S_BIT_LOW  = 3'd5;
  localparam logic [2:0] S_BIT_REC  = 3'd6;
  localparam logic [2:0] S_DONE     = 3'd7;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic [8:0]    us_q, us_d, dur;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic [5:0]    count_q, count_d;
  logic [4:0]    addr_q, addr_d;
  logic [7:0]    data_q, data_d;
  logic [2:0]    bit_q, bit_d;
  logic          busy_q, busy_d, error_q, error_d;
  logic          tick, last, bit_val, entering;
`ifdef ONE_WIRE_TX_PRESENCE_EN
  logic [1:0]    ow_sync_q;
  logic          presence_q, presence_d;
`endif

  assign tick    = cyc_q == CW'(CLKS_PER_US - 1);
  assign bit_val = data_q[bit_q];
  assign dur = state_q == S_RST_LOW  ? 9'd480 :
               state_q == S_RST_WAIT ? 9'd70  :
               state_q == S_RST_REC  ? 9'd410 :
               state_q == S_BIT_LOW  ? (bit_val ? 9'd6 : 9'd60) :
                                       (bit_val ? 9'd64 : 9'd10);
  assign last     = tick && (us_q == dur - 9'd1);
  assign entering = state_d != state_q;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    addr_d  = addr_q;
    data_d  = data_q;
    bit_d   = bit_q;
    busy_d  = busy_q;
    error_d = error_q;
`ifdef ONE_WIRE_TX_PRESENCE_EN
    presence_d = presence_q;
`endif
    case (state_q)
      S_IDLE: if (bus.start) begin
        count_d = bus.byte_count > 6'd32 ? 6'd32 : bus.byte_count;
        error_d = 1'b0;
        busy_d  = 1'b1;
        state_d = S_RST_LOW;
`ifdef ONE_WIRE_TX_PRESENCE_EN
        presence_d = 1'b0;
`endif
      end
      S_RST_LOW: if (last) state_d = S_RST_WAIT;
      S_RST_WAIT: if (last) begin
`ifdef ONE_WIRE_TX_PRESENCE_EN
        presence_d = ~ow_sync_q[1];
`endif
        state_d = S_RST_REC;
      end
      S_RST_REC: if (last) begin
        addr_d  = '0;
        state_d = count_q == 6'd0 ? S_DONE : S_FETCH;
`ifdef ONE_WIRE_TX_PRESENCE_EN
        if (!presence_q) begin
          error_d = 1'b1;
          state_d = S_DONE;
        end
`endif
      end
      S_FETCH: if (bus.data_dv) begin
        data_d  = bus.data_in;
        bit_d   = 3'd0;
        state_d = S_BIT_LOW;
      end else if (fcnt_q == FW'(FETCH_TIMEOUT - 1)) begin
        error_d = 1'b1;
        state_d = S_DONE;
      end
      S_BIT_LOW: if (last) state_d = S_BIT_REC;
      S_BIT_REC: if (last) begin
        bit_d   = bit_q + 3'd1;
        state_d = S_BIT_LOW;
        if (bit_q == 3'd7) begin
          addr_d  = addr_q + 5'd1;
          state_d = ({1'b0, addr_q} + 6'd1 == count_q) ? S_DONE : S_FETCH;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Timebase restarts on every state change so each phase length is an exact µs multiple.
  assign cyc_d  = (state_q == S_IDLE || entering || tick) ? '0 : cyc_q + CW'(1);
  assign us_d   = (state_q == S_IDLE || entering) ? '0 : tick ? us_q + 9'd1 : us_q;
  assign fcnt_d = (state_q != S_FETCH || entering) ? '0 : fcnt_q + FW'(1);

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= S_IDLE;
      cyc_q   <= '0;
      us_q    <= '0;
      fcnt_q  <= '0;
      count_q <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      bit_q   <= '0;
      busy_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      us_q    <= us_d;
      fcnt_q  <= fcnt_d;
      count_q <= count_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      bit_q   <= bit_d;
      busy_q  <= busy_d;
      error_q <= error_d;
    end
  end

`ifdef ONE_WIRE_TX_PRESENCE_EN
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      ow_sync_q  <= 2'b11;
      presence_q <= 1'b0;
    end else begin
      ow_sync_q  <= {ow_sync_q[0], bus.ow_in};
      presence_q <= presence_d;
    end
  end
  assign bus.presence = presence_q;
`else
  assign bus.presence = 1'b0;
`endif

  assign bus.read_address = addr_q;
  assign bus.read_en      = state_q == S_FETCH;
  assign bus.ow_drive_low = state_q == S_RST_LOW || state_q == S_BIT_LOW;
  assign bus.busy         = busy_q;
  assign bus.done         = state_q == S_DONE;
  assign bus.error        = error_q;
endmodule

// File: tb/tb_one_wire_tx.sv
// tb_one_wire_tx: directed checks of one_wire_tx slot timing, buffer fetches and error paths.
module tb_one_wire_tx;
`ifdef ONE_WIRE_TX_PRESENCE_EN
  localparam bit PRES = 1'b1;
`else
  localparam bit PRES = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset_ni = 1'b0;
  always #5 clk = ~clk;

  one_wire_tx_if bus();
  one_wire_tx #(.CLKS_PER_US(2)) dut (.clk_i(clk), .reset_ni(reset_ni), .bus(bus));

  int checks = 0, errors = 0;
  int lows[$], highs[$], addrs[$], rlens[$];
  int lrun = 0, hrun = 0, rrun = 0, rc = 0, rel = 100000, dones = 0, lat = 1;
  bit seen_low = 1'b0, dev_present = 1'b1, prev_re = 1'b0;
  logic [7:0] mem [32];

  // Device pulls the bus low 30..150 µs after a reset pulse when present.
  assign bus.ow_in = !bus.ow_drive_low && !(dev_present && rel >= 60 && rel < 300);

  always @(negedge clk) begin
    if (bus.ow_drive_low) begin
      if (seen_low && hrun > 0) highs.push_back(hrun);
      hrun = 0;
      lrun++;
    end else begin
      if (lrun > 0) begin
        lows.push_back(lrun);
        seen_low = 1'b1;
        if (lrun >= 900) rel = 0;
      end
      lrun = 0;
      if (seen_low) hrun++;
      if (rel < 100000) rel++;
    end
    if (bus.read_en && !prev_re) addrs.push_back(int'(bus.read_address));
    if (bus.read_en) rrun++;
    else if (prev_re) begin
      rlens.push_back(rrun);
      rrun = 0;
    end
    prev_re = bus.read_en;
    rc = bus.read_en ? rc + 1 : 0;
    bus.data_dv = bus.read_en && rc == lat;
    bus.data_in = mem[bus.read_address];
    if (bus.done) dones++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic go(input logic [5:0] count);
    lows.delete(); highs.delete(); addrs.delete(); rlens.delete();
    lrun = 0; hrun = 0; rrun = 0; seen_low = 1'b0;
    bus.byte_count = count;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("busy_rise", bus.busy, 1);
    check("low_rise", bus.ow_drive_low, 1);
  endtask

  task automatic wait_done(input int bound);
    int n = 0;
    while (!bus.done && n < bound) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", bus.done, 1);
  endtask

  int slot1 [8] = '{12, 120, 12, 120, 120, 12, 120, 12};
  int d0;

  initial begin
    bus.start = 1'b0;
    bus.byte_count = '0;
    for (int i = 0; i < 32; i++) mem[i] = 8'(i * 37 + 5);
    repeat (3) @(negedge clk);
    check("reset_outs", {bus.ow_drive_low, bus.read_en, bus.busy, bus.done, bus.presence,
                         bus.error, bus.read_address}, 0);
    reset_ni = 1'b1;
    @(negedge clk);

    mem[0] = 8'hA5; lat = 1; dev_present = 1'b1;
    go(6'd1);
    wait_done(20000);
    check("t1_presence", bus.presence, PRES);
    check("t1_error", bus.error, 0);
    check("t1_nlows", lows.size(), 9);
    check("t1_rst_low", lows[0], 960);
    check("t1_rst_high", highs[0], 961);
    for (int i = 0; i < 8; i++) check($sformatf("t1_low%0d", i), lows[i+1], slot1[i]);
    for (int i = 1; i < 8; i++) check($sformatf("t1_slot%0d", i), lows[i] + highs[i], 140);
    @(negedge clk);
    check("t1_done_pulse", {bus.done, bus.busy}, 0);

    mem[0] = 8'h3C; mem[1] = 8'h81; mem[2] = 8'hFF; lat = 2;
    go(6'd3);
    repeat (500) @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(40000);
    check("t2_error", bus.error, 0);
    check("t2_naddr", addrs.size(), 3);
    for (int i = 0; i < 3; i++) check($sformatf("t2_addr%0d", i), addrs[i], i);
    check("t2_nlows", lows.size(), 25);
    check("t2_rlen", rlens[0], 2);
    for (int b = 0; b < 3; b++)
      for (int k = 0; k < 8; k++)
        check($sformatf("t2_low%0d_%0d", b, k), lows[1+8*b+k], mem[b][k] ? 12 : 120);
    @(negedge clk);

    mem[0] = 8'h5A; lat = 1; dev_present = 1'b0;
    go(6'd1);
    wait_done(20000);
    check("t3_error", bus.error, PRES);
    check("t3_presence", bus.presence, 0);
    check("t3_nlows", lows.size(), PRES ? 1 : 9);
    check("t3_naddr", addrs.size(), PRES ? 0 : 1);
    @(negedge clk);

    dev_present = 1'b1; lat = -1;
    go(6'd1);
    wait_done(20000);
    check("t4_error", bus.error, 1);
    check("t4_released", bus.ow_drive_low, 0);
    @(negedge clk);
    check("t4_nrlen", rlens.size(), 1);
    check("t4_rlen", rlens[0], 15);
    check("t4_nlows", lows.size(), 1);

    for (int i = 0; i < 32; i++) mem[i] = 8'(i * 7 + 1);
    lat = 1;
    go(6'd40);
    wait_done(60000);
    check("t5_error", bus.error, 0);
    check("t5_naddr", addrs.size(), 32);
    for (int i = 0; i < 32; i++) check($sformatf("t5_addr%0d", i), addrs[i], i);
    check("t5_nlows", lows.size(), 257);
    @(negedge clk);

    mem[0] = 8'h00;
    go(6'd1);
    begin
      int n = 0;
      while (!(lows.size() == 1 && lrun >= 20) && n < 5000) begin
        @(negedge clk);
        n++;
      end
    end
    check("t6_armed", lows.size() == 1 && lrun >= 20, 1);
    d0 = dones;
    #2 reset_ni = 1'b0;
    #1;
    check("t6_async", {bus.ow_drive_low, bus.read_en, bus.busy}, 0);
    repeat (3) @(negedge clk);
    reset_ni = 1'b1;
    repeat (200) @(negedge clk);
    check("t6_no_done", dones, d0);
    check("t6_idle", {bus.busy, bus.ow_drive_low, bus.read_en}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
